// File: rtl/frame_align_if.sv
// Byte-stream bundle between the line receiver, the frame aligner and the demapper.
// Row/column widths cover 4 rows and up to 2048 columns.
interface frame_align_if;
    logic [7:0]  i_line_data;
    logic        i_line_data_valid;
    logic [7:0]  o_frame_data;
    logic        o_frame_data_valid;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_frame_start;
    logic        o_locked;

    modport master (
        output i_line_data, i_line_data_valid,
        input  o_frame_data, o_frame_data_valid, o_row_cnt, o_col_cnt, o_frame_start, o_locked
    );

    modport slave (
        input  i_line_data, i_line_data_valid,
        output o_frame_data, o_frame_data_valid, o_row_cnt, o_col_cnt, o_frame_start, o_locked
    );
endinterface

// File: rtl/frame_align.sv
// Receive frame aligner: hunts for the F6F6F6282828 alignment word, verifies and holds lock,
// and forwards each byte one cycle later tagged with its row/column position.
module frame_align #(
    parameter int ROW_LEN       = 1041,
    parameter int VERIFY_FRAMES = 2,
    parameter int LOSS_FRAMES   = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    frame_align_if.slave bus
);
    localparam logic [47:0] FAS      = 48'hF6F6F6_282828;
    localparam logic [10:0] COL_LAST = 11'(ROW_LEN - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_r;
    logic [47:0] hist_r;
    logic [1:0]  row_r;
    logic [10:0] col_r;
    logic [7:0]  good_r;
    logic [7:0]  bad_r;
    logic        fas_ok_r;

    logic [47:0] hist_next_s;
    logic [1:0]  row_next_s;
    logic [10:0] col_next_s;
    logic        fas_hit_s;
    logic        fas_ok_s;
    logic        in_fas_s;
    logic        fas_check_s;

    function automatic logic [7:0] fas_byte(input logic [10:0] col);
        case (col)
            11'd0, 11'd1, 11'd2: fas_byte = 8'hF6;
            11'd3, 11'd4, 11'd5: fas_byte = 8'h28;
            default:             fas_byte = 8'h00;
        endcase
    endfunction

    // Position of the byte after the current one.
    always_comb begin
        if (col_r == COL_LAST) begin
            col_next_s = 11'd0;
            row_next_s = row_r + 2'd1;
        end else begin
            col_next_s = col_r + 11'd1;
            row_next_s = row_r;
        end
    end

    // Per-frame FAS comparison, accumulated over row 0 cols 0-5 and judged at col 5.
    always_comb begin
        hist_next_s = {hist_r[39:0], bus.i_line_data};
        in_fas_s    = (row_r == 2'd0) && (col_r < 11'd6);
        fas_check_s = (row_r == 2'd0) && (col_r == 11'd5);
        fas_hit_s   = (bus.i_line_data == fas_byte(col_r));
        if (col_r == 11'd0) begin
            fas_ok_s = fas_hit_s;
        end else begin
            fas_ok_s = fas_ok_r & fas_hit_s;
        end
    end

    // Alignment state machine, position counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r                <= SEARCH;
            hist_r                 <= 48'd0;
            row_r                  <= 2'd0;
            col_r                  <= 11'd0;
            good_r                 <= 8'd0;
            bad_r                  <= 8'd0;
            fas_ok_r               <= 1'b0;
            bus.o_frame_data       <= 8'd0;
            bus.o_frame_data_valid <= 1'b0;
            bus.o_row_cnt          <= 2'd0;
            bus.o_col_cnt          <= 11'd0;
            bus.o_frame_start      <= 1'b0;
            bus.o_locked           <= 1'b0;
        end else if (bus.i_line_data_valid) begin
            bus.o_frame_data       <= bus.i_line_data;
            bus.o_row_cnt          <= row_r;
            bus.o_col_cnt          <= col_r;
            bus.o_frame_data_valid <= (state_r == LOCKED);
            bus.o_locked           <= (state_r == LOCKED);
            bus.o_frame_start      <= (state_r == LOCKED) && (row_r == 2'd0) && (col_r == 11'd0);
            row_r                  <= row_next_s;
            col_r                  <= col_next_s;
            if (in_fas_s) begin
                fas_ok_r <= fas_ok_s;
            end
            case (state_r)
                SEARCH: begin
                    hist_r <= hist_next_s;
                    if (hist_next_s == FAS) begin
                        state_r <= VERIFY;
                        good_r  <= 8'd0;
                        row_r   <= 2'd0;
                        col_r   <= 11'd6;
                    end
                end
                VERIFY: begin
                    if (fas_check_s) begin
                        if (!fas_ok_s) begin
                            state_r <= SEARCH;
                            hist_r  <= 48'd0;
                        end else if (good_r == 8'(VERIFY_FRAMES - 1)) begin
                            state_r <= LOCKED;
                            bad_r   <= 8'd0;
                        end else begin
                            good_r <= good_r + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (fas_check_s) begin
                        if (fas_ok_s) begin
                            bad_r <= 8'd0;
                        end else if (bad_r == 8'(LOSS_FRAMES - 1)) begin
                            state_r <= SEARCH;
                            hist_r  <= 48'd0;
                            bad_r   <= 8'd0;
                        end else begin
                            bad_r <= bad_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r <= SEARCH;
                    hist_r  <= 48'd0;
                end
            endcase
        end else begin
            bus.o_frame_data_valid <= 1'b0;
            bus.o_frame_start      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_frame_align.sv
// Bench for frame_align: full-size instance (1041/2/4) and a short-row instance (20/1/1),
// each checked every cycle against a position/mode model plus literal lock-timing checks.
module tb_frame_align;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_align_if ifc0 ();
    frame_align_if ifc1 ();

    frame_align #(.ROW_LEN(1041), .VERIFY_FRAMES(2), .LOSS_FRAMES(4)) u_big (
        .i_clk(clk), .i_rst(rst), .bus(ifc0.slave));
    frame_align #(.ROW_LEN(20), .VERIFY_FRAMES(1), .LOSS_FRAMES(1)) u_small (
        .i_clk(clk), .i_rst(rst), .bus(ifc1.slave));

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    logic [7:0] fas_tab [6] = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};

    // model state: mode 0 = hunting, 1 = confirming, 2 = locked; pos = row*rl + col
    int         m_mode [2];
    int         m_pos  [2];
    int         m_good [2];
    int         m_bad  [2];
    int         m_hn   [2];
    bit         m_err  [2];
    logic [7:0] m_h    [2][6];
    logic [7:0] e_data [2];
    logic       e_valid[2];
    logic       e_locked[2];
    logic       e_start[2];
    int         e_row  [2];
    int         e_col  [2];

    // bench bookkeeping
    int   beat_no  [2];
    int   s_pos    [2];
    int   rise_beat[2];
    int   fall_beat[2];
    int   rise_row [2];
    int   rise_col [2];
    int   n_start  [2];
    int   n_valid  [2];
    logic prev_l   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int id);
        m_mode[id] = 0; m_pos[id] = 0; m_good[id] = 0; m_bad[id] = 0; m_hn[id] = 0; m_err[id] = 1'b0;
        e_data[id] = 8'd0; e_valid[id] = 1'b0; e_locked[id] = 1'b0; e_start[id] = 1'b0;
        e_row[id] = 0; e_col[id] = 0;
    endtask

    task automatic model_step(input int id, input logic [7:0] d, input int rl, input int vf, input int lf);
        int  p;
        bit  all_eq;
        p = m_pos[id];
        e_data[id]   = d;
        e_row[id]    = p / rl;
        e_col[id]    = p % rl;
        e_valid[id]  = (m_mode[id] == 2);
        e_locked[id] = (m_mode[id] == 2);
        e_start[id]  = (m_mode[id] == 2) && (p == 0);
        if (p < 6) m_err[id] = ((p == 0) ? 1'b0 : m_err[id]) | (d != fas_tab[p]);
        m_pos[id] = (p + 1) % (4 * rl);
        if (m_mode[id] == 0) begin
            for (int k = 0; k < 5; k++) m_h[id][k] = m_h[id][k+1];
            m_h[id][5] = d;
            if (m_hn[id] < 6) m_hn[id]++;
            all_eq = (m_hn[id] == 6);
            for (int k = 0; k < 6; k++) if (m_h[id][k] != fas_tab[k]) all_eq = 1'b0;
            if (all_eq) begin
                m_mode[id] = 1; m_good[id] = 0; m_pos[id] = 6;
            end
        end else if (p == 5) begin
            if (m_mode[id] == 1) begin
                if (m_err[id]) begin
                    m_mode[id] = 0; m_hn[id] = 0;
                end else begin
                    m_good[id]++;
                    if (m_good[id] == vf) begin m_mode[id] = 2; m_bad[id] = 0; end
                end
            end else if (!m_err[id]) begin
                m_bad[id] = 0;
            end else begin
                m_bad[id]++;
                if (m_bad[id] == lf) begin m_mode[id] = 0; m_hn[id] = 0; end
            end
        end
    endtask

    // Reference model, advanced on the same edges as the DUTs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            if (ifc0.i_line_data_valid) model_step(0, ifc0.i_line_data, 1041, 2, 4);
            else begin e_valid[0] = 1'b0; e_start[0] = 1'b0; end
            if (ifc1.i_line_data_valid) model_step(1, ifc1.i_line_data, 20, 1, 1);
            else begin e_valid[1] = 1'b0; e_start[1] = 1'b0; end
        end
    end

    task automatic cmp_dut(input int id, input logic [7:0] d, input logic v, input logic [1:0] r,
                           input logic [10:0] c, input logic s, input logic l);
        check($sformatf("u%0d_data", id), 32'(d), 32'(e_data[id]));
        check($sformatf("u%0d_valid", id), 32'(v), 32'(e_valid[id]));
        check($sformatf("u%0d_locked", id), 32'(l), 32'(e_locked[id]));
        check($sformatf("u%0d_start", id), 32'(s), 32'(e_start[id]));
        if (e_valid[id]) begin
            check($sformatf("u%0d_row", id), 32'(r), 32'(e_row[id]));
            check($sformatf("u%0d_col", id), 32'(c), 32'(e_col[id]));
        end
        if (l && !prev_l[id]) begin
            rise_beat[id] = beat_no[id] - 1; rise_row[id] = int'(r); rise_col[id] = int'(c);
        end
        if (!l && prev_l[id]) fall_beat[id] = beat_no[id] - 1;
        prev_l[id] = l;
        if (s) n_start[id]++;
        if (v) n_valid[id]++;
    endtask

    // Single compare point, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, ifc0.o_frame_data, ifc0.o_frame_data_valid, ifc0.o_row_cnt, ifc0.o_col_cnt,
                    ifc0.o_frame_start, ifc0.o_locked);
            cmp_dut(1, ifc1.o_frame_data, ifc1.o_frame_data_valid, ifc1.o_row_cnt, ifc1.o_col_cnt,
                    ifc1.o_frame_start, ifc1.o_locked);
        end
    end

    function automatic logic [7:0] gen(input int p, input bit bad_fas);
        if (p < 6) return (bad_fas && p == 2) ? 8'h00 : fas_tab[p];
        return 8'(p);
    endfunction

    task automatic beat(input int id, input logic [7:0] d, input logic v);
        @(negedge clk);
        if (id == 0) begin
            ifc0.i_line_data = d; ifc0.i_line_data_valid = v; ifc1.i_line_data_valid = 1'b0;
        end else begin
            ifc1.i_line_data = d; ifc1.i_line_data_valid = v; ifc0.i_line_data_valid = 1'b0;
        end
        @(posedge clk);
        if (v) beat_no[id]++;
    endtask

    task automatic idle(input int id, input int n);
        for (int i = 0; i < n; i++) beat(id, 8'hA5, 1'b0);
    endtask

    task automatic send(input int id, input int n, input int rl, input bit bad_fas, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) beat(id, 8'($urandom_range(0, 255)), 1'b0);
            beat(id, gen(s_pos[id], bad_fas), 1'b1);
            s_pos[id] = (s_pos[id] + 1) % (4 * rl);
        end
    endtask

    task automatic clear_marks(input int id);
        beat_no[id] = 0; rise_beat[id] = -1; fall_beat[id] = -1;
        rise_row[id] = -1; rise_col[id] = -1; n_start[id] = 0; n_valid[id] = 0;
    endtask

    initial begin
        logic [7:0] nz;
        ifc0.i_line_data = 8'd0; ifc0.i_line_data_valid = 1'b0;
        ifc1.i_line_data = 8'd0; ifc1.i_line_data_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin prev_l[i] = 1'b0; s_pos[i] = 0; clear_marks(i); end
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(ifc0.o_locked), 32'd0);
        check("rst_valid", 32'(ifc0.o_frame_data_valid), 32'd0);
        check("rst_col", 32'(ifc0.o_col_cnt), 32'd0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // clean frames: lock on the byte after the third FAS
        clear_marks(0);
        send(0, 4 * 4164 + 10, 1041, 1'b0, 1'b0);
        idle(0, 2);
        check("t1_lock_beat", 32'(rise_beat[0]), 32'd8334);
        check("t1_first_row", 32'(rise_row[0]), 32'd0);
        check("t1_first_col", 32'(rise_col[0]), 32'd6);
        check("t1_starts", 32'(n_start[0]), 32'd2);
        check("t1_no_loss", 32'(fall_beat[0]), 32'hFFFF_FFFF);

        // gapped valid across a full frame: wraps through row 3 col 1040
        clear_marks(0);
        send(0, 4 * 1041 - 10 + 30, 1041, 1'b0, 1'b1);
        idle(0, 2);
        check("t4_starts", 32'(n_start[0]), 32'd1);
        check("t4_valid_beats", 32'(n_valid[0]), 32'(4 * 1041 + 20));
        check("t4_no_loss", 32'(fall_beat[0]), 32'hFFFF_FFFF);

        // asynchronous reset mid-payload while locked
        send(0, 5, 1041, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_locked", 32'(ifc0.o_locked), 32'd0);
        check("t5_rst_valid", 32'(ifc0.o_frame_data_valid), 32'd0);
        check("t5_rst_data", 32'(ifc0.o_frame_data), 32'd0);
        check("t5_rst_col", 32'(ifc0.o_col_cnt), 32'd0);
        idle(0, 3);
        @(negedge clk);
        rst = 1'b0;
        clear_marks(0);
        s_pos[0] = 0;
        send(0, 4 * 4164, 1041, 1'b0, 1'b0);
        idle(0, 1);
        check("t5_relock_beat", 32'(rise_beat[0]), 32'd8334);

        // three bad FAS then a good one hold lock; four bad in a row drop it
        clear_marks(0);
        send(0, 3 * 4164, 1041, 1'b1, 1'b0);
        send(0, 4164, 1041, 1'b0, 1'b0);
        check("t3_held", 32'(ifc0.o_locked), 32'd1);
        send(0, 4 * 4164, 1041, 1'b1, 1'b0);
        send(0, 10, 1041, 1'b0, 1'b0);
        idle(0, 2);
        check("t3_loss_beat", 32'(fall_beat[0]), 32'd29154);
        check("t3_unlocked", 32'(ifc0.o_locked), 32'd0);

        // isolated FAS inside noise never produces valid output
        clear_marks(0);
        for (int i = 0; i < 4230; i++) begin
            nz = 8'($urandom_range(0, 255));
            if (nz == 8'hF6 || nz == 8'h28) nz = 8'h55;
            if (i >= 20 && i < 26) nz = fas_tab[i - 20];
            beat(0, nz, 1'b1);
        end
        idle(0, 2);
        check("t2_no_valid", 32'(n_valid[0]), 32'd0);
        check("t2_no_lock", 32'(rise_beat[0]), 32'hFFFF_FFFF);

        // short rows, single-frame verify and loss
        clear_marks(1);
        s_pos[1] = 0;
        send(1, 240, 20, 1'b0, 1'b0);
        send(1, 80, 20, 1'b1, 1'b0);
        send(1, 10, 20, 1'b0, 1'b0);
        idle(1, 2);
        check("t6_lock_beat", 32'(rise_beat[1]), 32'd86);
        check("t6_first_col", 32'(rise_col[1]), 32'd6);
        check("t6_loss_beat", 32'(fall_beat[1]), 32'd246);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_align.md
Name: frame_align

Overview:
Receive-side frame aligner. It sits directly upstream of the demapper payload-extraction stage. It searches the raw received byte stream for the frame alignment signal (FAS), confirms and holds frame lock, and forwards each byte tagged with its row and column position. Its outputs drive the demapper's frame data, data valid, row count and column count inputs directly.

Parameters:
ROW_LEN, 1041, columns per row (0..ROW_LEN-1). Cols 0-15 are overhead, 16-1039 are payload, 1040 is pad.
VERIFY_FRAMES, 2, consecutive good FAS frames required after a candidate match before lock is declared.
LOSS_FRAMES, 4, consecutive bad FAS frames while locked before lock is dropped.

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  asynchronous, active-high reset
i_line_data  in  8  received line byte
i_line_data_valid  in  1  i_line_data qualifier; counters and state advance only on valid
o_frame_data  out  8  registered copy of i_line_data
o_frame_data_valid  out  1  high only for bytes accepted while LOCKED
o_row_cnt  out  2  row (0..3) of o_frame_data
o_col_cnt  out  11  column (0..ROW_LEN-1) of o_frame_data
o_frame_start  out  1  one-cycle pulse with the row 0 col 0 output byte while LOCKED
o_locked  out  1  high while the state is LOCKED

Behaviour:
- FAS is the 6 bytes F6 F6 F6 28 28 28, occupying row 0 cols 0-5. Row 0 col 6 is ARQ_EN, passed through like any other byte.
- Reset (async assert, sync-safe release):
  - all outputs 0; state = SEARCH.
  - 48-bit byte history, row/col counters, good/bad frame counters cleared.
  - A cleared history can never match FAS.
- Reset mid-frame discards all alignment; the block restarts in SEARCH.
- Cycles without i_line_data_valid: no state, counter or history change; o_frame_data_valid = 0 and o_frame_start = 0 that cycle; o_frame_data, o_row_cnt and o_col_cnt hold.
- Position counters (row, col) give the position of the current input byte:
  - col increments per valid byte; at ROW_LEN-1 it wraps to 0 and row increments.
  - row 3, col ROW_LEN-1 wraps to row 0, col 0.
- Latency is exactly 1 cycle. o_frame_data, o_row_cnt and o_col_cnt are registered together from the same input beat, so data and position are always aligned.
- SEARCH:
  - History shifts in each valid byte.
  - When the history (newest byte included) equals FAS, the current byte is taken as col 5 of row 0. Next position = row 0, col 6. Go to VERIFY with good_cnt = 0.
  - o_frame_data_valid = 0.
- VERIFY:
  - Counters run. Bytes at row 0 cols 0-5 are compared against FAS, accumulating a per-frame fas_ok flag that is evaluated at col 5.
  - Good FAS: good_cnt++. When good_cnt reaches VERIFY_FRAMES, go to LOCKED, effective from the next byte (row 0 col 6).
  - Any mismatch: go to SEARCH with history cleared.
  - o_frame_data_valid = 0.
- LOCKED:
  - Every valid byte is output with o_frame_data_valid = 1, including FAS bytes.
  - At col 5 of row 0: good FAS sets bad_cnt = 0; bad FAS does bad_cnt++.
  - When bad_cnt reaches LOSS_FRAMES, go to SEARCH. o_locked and o_frame_data_valid fall from the next valid byte.
  - The erroneous FAS bytes of a frame that does not yet cause loss are still forwarded as valid.
- o_locked is registered and updates in the same cycle as o_frame_data_valid.
- o_frame_start = o_frame_data_valid AND o_row_cnt==0 AND o_col_cnt==0.

Test Plan:
1. Reset, then clean frames (FAS + incrementing payload, 4164 bytes/frame), valid continuous -> o_locked rises on the first byte after the 3rd FAS (initial match + 2 verified). The first valid output is row 0 col 6; o_frame_start pulses at each later row 0 col 0. Output equals input delayed 1 cycle.
2. Random noise containing one isolated FAS pattern, no FAS one frame later -> enters VERIFY, returns to SEARCH at the next col 5 check; o_frame_data_valid never asserts.
3. Locked, then 3 frames with FAS byte 2 = 0x00 followed by a good frame -> lock held, bad_cnt resets; then 4 consecutive bad frames -> o_locked falls on the byte after the 4th bad col 5.
4. Locked with i_line_data_valid toggled 1-0-1 randomly -> col/row advance only on valid beats; o_frame_data_valid = 0 on gap cycles; col 1040 wraps to col 0 of the next row, and row 3 wraps to row 0.
5. Assert i_rst mid-payload while locked -> all outputs 0 immediately (asynchronous); after release, relock takes the same time as scenario 1.
6. ROW_LEN=20, VERIFY_FRAMES=1, LOSS_FRAMES=1 -> lock after the 2nd FAS; a single bad FAS drops lock.
